// File: rtl/micro_sequencer_if.sv
// Sequencer handshake bundle: run control and instruction-register inputs in,
// microstate, run status and retired-instruction count out.
interface micro_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             halt_req;
    logic [5:0]       opcode;
    logic [1:0]       seq_ctl;
    logic             wait_req;
    logic [3:0]       state;
    logic             running;
    logic             ctrl_en;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output start, halt_req, opcode, seq_ctl, wait_req,
        input  state, running, ctrl_en, illegal, instr_cnt
    );

    modport slave (
        input  start, halt_req, opcode, seq_ctl, wait_req,
        output state, running, ctrl_en, illegal, instr_cnt
    );
endinterface

// File: rtl/micro_sequencer.sv
// Registered microstate engine for the multi-cycle controller ROM address.
// Define MICRO_SEQUENCER_TRAP_EN to trap illegal dispatches into TRAP_STATE and stop.
module micro_sequencer #(
    parameter logic [3:0] FETCH_STATE = 4'h0,
    parameter logic [3:0] TRAP_STATE  = 4'hF,
    parameter int         CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    micro_sequencer_if.slave  sq
);
    typedef enum logic {IDLE, RUN} run_e;

    localparam logic [1:0] SEQ_NEXT  = 2'b00;
    localparam logic [1:0] SEQ_DISP1 = 2'b01;
    localparam logic [1:0] SEQ_DISP2 = 2'b10;
    localparam logic [1:0] SEQ_FETCH = 2'b11;

    run_e             run_q, run_d;
    logic [3:0]       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hp_q, hp_d;
    logic             bad;
    logic             d1_ok, d2_ok;
    logic [3:0]       d1_tgt, d2_tgt;
    logic             running;
`ifdef MICRO_SEQUENCER_TRAP_EN
    logic             ill_q, ill_d;
`else
    logic             unused_trap;
    assign unused_trap = ^TRAP_STATE;
`endif

    // Dispatch ROMs, decoded straight from the instruction register opcode
    always_comb begin
        d1_ok  = 1'b1;
        d1_tgt = FETCH_STATE;
        case (sq.opcode)
            6'h00:   d1_tgt = 4'd6;
            6'h23:   d1_tgt = 4'd2;
            6'h2B:   d1_tgt = 4'd2;
            6'h04:   d1_tgt = 4'd8;
            6'h02:   d1_tgt = 4'd9;
            6'h08:   d1_tgt = 4'd10;
            default: d1_ok  = 1'b0;
        endcase
        d2_ok  = 1'b1;
        d2_tgt = FETCH_STATE;
        case (sq.opcode)
            6'h23:   d2_tgt = 4'd3;
            6'h2B:   d2_tgt = 4'd5;
            default: d2_ok  = 1'b0;
        endcase
    end

    always_comb begin
        run_d = run_q;
        st_d  = st_q;
        cnt_d = cnt_q;
        hp_d  = hp_q;
        bad   = 1'b0;
`ifdef MICRO_SEQUENCER_TRAP_EN
        ill_d = ill_q;
`endif
        case (run_q)
            IDLE: begin
                if (sq.start) begin
                    run_d = RUN;
                    st_d  = FETCH_STATE;
                    hp_d  = 1'b0;
`ifdef MICRO_SEQUENCER_TRAP_EN
                    ill_d = 1'b0;
`endif
                end
            end
            RUN: begin
                // A halt seen during a memory wait must still be remembered
                if (sq.halt_req)
                    hp_d = 1'b1;
                if (!sq.wait_req) begin
                    case (sq.seq_ctl)
                        SEQ_NEXT:  st_d = st_q + 4'd1;
                        SEQ_DISP1: if (d1_ok) st_d = d1_tgt; else bad = 1'b1;
                        SEQ_DISP2: if (d2_ok) st_d = d2_tgt; else bad = 1'b1;
                        SEQ_FETCH: begin
                            cnt_d = cnt_q + 1'b1;
                            st_d  = FETCH_STATE;
                            if (hp_q || sq.halt_req) begin
                                run_d = IDLE;
                                hp_d  = 1'b0;
                            end
                        end
                        default: st_d = st_q;
                    endcase
                    if (bad) begin
`ifdef MICRO_SEQUENCER_TRAP_EN
                        st_d  = TRAP_STATE;
                        ill_d = 1'b1;
                        run_d = IDLE;
                        hp_d  = 1'b0;
`else
                        st_d  = FETCH_STATE;
`endif
                    end
                end
            end
            default: run_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= IDLE;
            st_q  <= FETCH_STATE;
            cnt_q <= '0;
            hp_q  <= 1'b0;
        end else begin
            run_q <= run_d;
            st_q  <= st_d;
            cnt_q <= cnt_d;
            hp_q  <= hp_d;
        end
    end

`ifdef MICRO_SEQUENCER_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ill_q <= 1'b0;
        else        ill_q <= ill_d;
    end
    assign sq.illegal = ill_q;
`else
    assign sq.illegal = 1'b0;
`endif

    assign running      = (run_q == RUN);
    assign sq.running   = running;
    assign sq.state     = st_q;
    assign sq.instr_cnt = cnt_q;
    assign sq.ctrl_en   = running & ~sq.wait_req;
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a table-driven reference model is compared
// against the outputs every cycle, plus literal expectations along the way.
module tb_micro_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    micro_sequencer_if #(.CNT_W(16)) bus();

    micro_sequencer #(
        .FETCH_STATE(4'h0),
        .TRAP_STATE (4'hF),
        .CNT_W      (16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sq   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: microstate, run flag, sticky illegal, counter, pending halt
    int d1[int];
    int d2[int];
    bit m_run, m_ill, m_hp, m_ok;
    int m_state, m_cnt, m_tgt;
    int prev_cnt;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_ill = 0; m_hp = 0; m_state = 0; m_cnt = 0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_run = 1; m_ill = 0; m_hp = 0; m_state = 0;
            end
        end else begin
            if (bus.halt_req) m_hp = 1;
            if (!bus.wait_req) begin
                m_ok = 1; m_tgt = 0;
                if (bus.seq_ctl == 2'd1) begin
                    if (d1.exists(int'(bus.opcode))) m_tgt = d1[int'(bus.opcode)]; else m_ok = 0;
                end
                if (bus.seq_ctl == 2'd2) begin
                    if (d2.exists(int'(bus.opcode))) m_tgt = d2[int'(bus.opcode)]; else m_ok = 0;
                end
                if (bus.seq_ctl == 2'd0) begin
                    m_state = (m_state + 1) % 16;
                end else if (bus.seq_ctl == 2'd3) begin
                    m_cnt = (m_cnt + 1) % 65536;
                    m_state = 0;
                    if (m_hp) begin m_run = 0; m_hp = 0; end
                end else if (m_ok) begin
                    m_state = m_tgt;
                end else begin
`ifdef MICRO_SEQUENCER_TRAP_EN
                    m_state = 15; m_ill = 1; m_run = 0; m_hp = 0;
`else
                    m_state = 0;
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("state",     bus.state,     m_state);
            chk("running",   bus.running,   m_run);
            chk("ctrl_en",   bus.ctrl_en,   m_run && !bus.wait_req);
            chk("illegal",   bus.illegal,   m_ill);
            chk("instr_cnt", bus.instr_cnt, m_cnt);
        end
    end

    task automatic cyc(input bit st, input bit hr, input logic [5:0] op,
                       input logic [1:0] sc, input bit wr);
        bus.start = st; bus.halt_req = hr; bus.opcode = op;
        bus.seq_ctl = sc; bus.wait_req = wr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        logic [5:0] ops [3];
        int tgts [3];
        d1[6'h00] = 6; d1[6'h23] = 2; d1[6'h2B] = 2;
        d1[6'h04] = 8; d1[6'h02] = 9; d1[6'h08] = 10;
        d2[6'h23] = 3; d2[6'h2B] = 5;
        ops[0] = 6'h02; ops[1] = 6'h08; ops[2] = 6'h04;
        tgts[0] = 9; tgts[1] = 10; tgts[2] = 8;
        bus.start = 0; bus.halt_req = 0; bus.opcode = 0; bus.seq_ctl = 0; bus.wait_req = 0;

        #3;
        chk("rst_state", bus.state, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_ctrl_en", bus.ctrl_en, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_cnt", bus.instr_cnt, 0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // idle ignores halt and sequencing
        cyc(0, 1, 6'h00, 2'd0, 0);
        chk("idle_state", bus.state, 0);
        chk("idle_running", bus.running, 0);

        // start, then NEXT, DISP1(0x00), FETCH
        cyc(1, 0, 6'h00, 2'd0, 0);
        chk("start_state", bus.state, 0);
        chk("start_running", bus.running, 1);
        cyc(0, 0, 6'h00, 2'd0, 0);  chk("seq_next", bus.state, 1);
        cyc(0, 0, 6'h00, 2'd1, 0);  chk("seq_disp1_r", bus.state, 6);
        cyc(0, 0, 6'h00, 2'd3, 0);  chk("seq_fetch", bus.state, 0);
        chk("cnt_one", bus.instr_cnt, 1);

        // load with three wait cycles in state 3
        cyc(0, 0, 6'h23, 2'd0, 0);
        cyc(0, 0, 6'h23, 2'd1, 0);  chk("lw_disp1", bus.state, 2);
        cyc(0, 0, 6'h23, 2'd2, 0);  chk("lw_disp2", bus.state, 3);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 6'h23, 2'd0, 1);
            chk("wait_hold", bus.state, 3);
            chk("wait_ctrl_en", bus.ctrl_en, 0);
        end
        cyc(0, 0, 6'h23, 2'd0, 0);  chk("wait_release", bus.state, 4);
        chk("wait_ctrl_en_hi", bus.ctrl_en, 1);
        cyc(0, 0, 6'h23, 2'd3, 0);

        // store path and remaining DISP1 targets
        cyc(0, 0, 6'h2B, 2'd1, 0);  chk("sw_disp1", bus.state, 2);
        cyc(0, 0, 6'h2B, 2'd2, 0);  chk("sw_disp2", bus.state, 5);
        cyc(0, 0, 6'h2B, 2'd3, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, ops[i], 2'd1, 0);
            chk("disp1_tbl", bus.state, tgts[i]);
            cyc(0, 0, ops[i], 2'd3, 0);
        end

        // halt pulse in state 2 completes the instruction
        cyc(0, 0, 6'h23, 2'd0, 0);
        cyc(0, 0, 6'h23, 2'd1, 0);
        prev_cnt = m_cnt;
        cyc(0, 1, 6'h23, 2'd0, 0);  chk("halt_run1", bus.running, 1);
        cyc(0, 0, 6'h23, 2'd0, 0);  chk("halt_run2", bus.running, 1);
        cyc(0, 0, 6'h23, 2'd3, 0);
        chk("halt_run0", bus.running, 0);
        chk("halt_state", bus.state, 0);
        chk("halt_cnt", bus.instr_cnt, prev_cnt + 1);
        cyc(0, 0, 6'h00, 2'd0, 0);  chk("halted_hold", bus.state, 0);

        // microstate wrap 15 -> 0
        cyc(1, 0, 6'h00, 2'd0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 6'h00, 2'd0, 0);
        chk("state15", bus.state, 15);
        cyc(0, 0, 6'h00, 2'd0, 0);  chk("state_wrap", bus.state, 0);

        // counter wrap at 16'hFFFF
        guard = 0;
        while (m_cnt != 65535 && guard < 70000) begin
            cyc(0, 0, 6'h00, 2'd3, 0);
            guard++;
        end
        chk("cnt_ffff", bus.instr_cnt, 16'hFFFF);
        cyc(0, 0, 6'h00, 2'd3, 0);  chk("cnt_wrap", bus.instr_cnt, 0);

        // FETCH and halt_req in the same cycle
        cyc(0, 1, 6'h00, 2'd3, 0);
        chk("fh_cnt", bus.instr_cnt, 1);
        chk("fh_running", bus.running, 0);

        // illegal DISP1 opcode
        cyc(1, 0, 6'h00, 2'd0, 0);
        cyc(0, 0, 6'h00, 2'd0, 0);
        cyc(0, 0, 6'h3F, 2'd1, 0);
`ifdef MICRO_SEQUENCER_TRAP_EN
        chk("ill_state", bus.state, 15);
        chk("ill_flag", bus.illegal, 1);
        chk("ill_running", bus.running, 0);
        cyc(0, 0, 6'h00, 2'd0, 0);  chk("trap_hold", bus.state, 15);
`else
        chk("ill_state", bus.state, 0);
        chk("ill_flag", bus.illegal, 0);
        chk("ill_running", bus.running, 1);
`endif
        cyc(1, 0, 6'h00, 2'd3, 0);
        chk("restart_state", bus.state, 0);
        chk("restart_illegal", bus.illegal, 0);
        chk("restart_running", bus.running, 1);

        // asynchronous reset in state 8 during a wait
        cyc(0, 0, 6'h04, 2'd1, 0);  chk("st8", bus.state, 8);
        bus.wait_req = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", bus.state, 0);
        chk("arst_running", bus.running, 0);
        chk("arst_ctrl_en", bus.ctrl_en, 0);
        chk("arst_illegal", bus.illegal, 0);
        chk("arst_cnt", bus.instr_cnt, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
